// File: rtl/sle_cfg_pkg.sv
// ---------------------------------------------------------------------------
// sle_cfg_pkg
// Shared definitions for the SLE configuration loader:
//   - state_e      : FSM state encoding
//   - clog2        : ceiling log2, used to size the bit and timeout counters
// ---------------------------------------------------------------------------
package sle_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_FINISH = 3'd4,
        ST_ABORT  = 3'd5
    } state_e;

    // Ceiling log2 of n (clog2(1) = 0), usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sle_cfg_shift.sv
// ---------------------------------------------------------------------------
// sle_cfg_shift
// Shadow shift register and bit counter for the serial configuration word.
// Bits arrive LSB first; each accepted bit is written to shadow[bitcnt].
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : restart the bit counter (start of a new load)
//   i_shift      : accept i_sin this cycle
//   i_sin        : serial data bit
//   o_word       : shadow word including the bit accepted this cycle
//   o_last       : this cycle accepts bit WIDTH-1
// ---------------------------------------------------------------------------
module sle_cfg_shift
    import sle_cfg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_word,
    output logic             o_last
);

    localparam int CNT_W = clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [CNT_W-1:0] r_cnt;

    // Next shadow value: the addressed bit takes i_sin when shifting.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (i_shift) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    w_shadow_nxt[i] = i_sin;
                end else begin
                    w_shadow_nxt[i] = r_shadow[i];
                end
            end
        end else begin
            w_shadow_nxt = r_shadow;
        end
    end

    // The top registers o_word into D on the same edge that accepts the last
    // bit, so it must see the word with that bit already merged in.
    assign o_word = w_shadow_nxt;
    assign o_last = i_shift && (r_cnt == CNT_W'(WIDTH - 1));

    // Shadow register and bit counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shadow <= {WIDTH{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_shadow <= w_shadow_nxt;
            if (i_clear) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (i_shift) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

endmodule

// File: rtl/sle_cfg_loader.sv
// ---------------------------------------------------------------------------
// sle_cfg_loader
// Control stage for a bank of WIDTH SLE cells. Loads a serial word (or
// performs a clear) behind a START handshake, drives EN/SLn/SD/D for one
// commit cycle, then pulses DONE. A stalled stream aborts with ERR so the
// bank never sees a partial word.
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   START, CLR_REQ    : start request; CLR_REQ=1 selects a clear
//   SIN, SIN_VALID    : serial data (LSB first) and its qualifier
//   EN, SLn, SD, D    : bank controls (EN per cell, SLn active-low)
//   BUSY, DONE, ERR   : status; DONE/ERR are one-cycle pulses
// All outputs are registers that mirror a decode of the state register.
// ---------------------------------------------------------------------------
module sle_cfg_loader
    import sle_cfg_pkg::*;
#(
    parameter int   WIDTH   = 8,
    parameter int   TIMEOUT = 16,
    parameter logic CLR_VAL = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             CLR_REQ,
    input  logic             SIN,
    input  logic             SIN_VALID,
    output logic [WIDTH-1:0] EN,
    output logic             SLn,
    output logic             SD,
    output logic [WIDTH-1:0] D,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int TO_W = clog2(TIMEOUT + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [TO_W-1:0]  r_to;
    logic             w_start_load;
    logic             w_shift;
    logic             w_last;
    logic             w_to_expire;
    logic [WIDTH-1:0] w_word;

    logic [WIDTH-1:0] r_en;
    logic             r_sln;
    logic             r_sd;
    logic [WIDTH-1:0] r_d;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    assign w_start_load = (r_state == ST_IDLE) && START && !CLR_REQ;
    assign w_shift      = (r_state == ST_LOAD) && SIN_VALID;
    // Abort on the TIMEOUT-th consecutive empty cycle; a valid bit wins.
    assign w_to_expire  = (r_state == ST_LOAD) && !SIN_VALID &&
                          (r_to == TO_W'(TIMEOUT - 1));

    sle_cfg_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clear (w_start_load),
        .i_shift (w_shift),
        .i_sin   (SIN),
        .o_word  (w_word),
        .o_last  (w_last)
    );

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt = CLR_REQ ? ST_CLEAR : ST_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_state_nxt = ST_COMMIT;
                end else if (w_to_expire) begin
                    w_state_nxt = ST_ABORT;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_COMMIT: w_state_nxt = ST_FINISH;
            ST_CLEAR:  w_state_nxt = ST_FINISH;
            ST_FINISH: w_state_nxt = ST_IDLE;
            ST_ABORT:  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Saturating stall counter; only meaningful in LOAD, zero elsewhere.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_to <= {TO_W{1'b0}};
        end else if (r_state != ST_LOAD) begin
            r_to <= {TO_W{1'b0}};
        end else if (SIN_VALID) begin
            r_to <= {TO_W{1'b0}};
        end else if (r_to != TO_W'(TIMEOUT)) begin
            r_to <= r_to + TO_W'(1);
        end else begin
            r_to <= r_to;
        end
    end

    // Output registers, loaded from the next state so they track r_state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_en   <= {WIDTH{1'b0}};
            r_sln  <= 1'b1;
            r_sd   <= 1'b0;
            r_d    <= {WIDTH{1'b0}};
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_en   <= ((w_state_nxt == ST_COMMIT) || (w_state_nxt == ST_CLEAR)) ?
                      {WIDTH{1'b1}} : {WIDTH{1'b0}};
            r_sln  <= (w_state_nxt != ST_CLEAR);
            r_sd   <= (w_state_nxt == ST_CLEAR) ? CLR_VAL : 1'b0;
            r_d    <= (w_state_nxt == ST_COMMIT) ? w_word : r_d;
            r_busy <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_COMMIT) ||
                      (w_state_nxt == ST_CLEAR);
            r_done <= (w_state_nxt == ST_FINISH);
            r_err  <= (w_state_nxt == ST_ABORT);
        end
    end

    assign EN   = r_en;
    assign SLn  = r_sln;
    assign SD   = r_sd;
    assign D    = r_d;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign ERR  = r_err;

endmodule
